// File: rtl/mem_copy_pkg.sv
// rtl/mem_copy_pkg.sv - shared types and widths for the memory copy engine
// Purpose: FSM state encoding and the data/address widths shared with the
// 256x8 data memory instantiation.
package mem_copy_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - forward byte-block copy engine for the single-port data memory
// Purpose: copies `length` bytes from src_addr to dst_addr, one READ and one
// WRITE cycle per byte, using the memory's combinational read port and
// registered write port.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   start                    one-cycle request, honoured only in IDLE
//   src_addr, dst_addr       first source / destination address
//   length                   byte count 0..2**A
//   busy, done               engine owns the memory port / completion pulse
//   mem_addr, mem_read_enabled, mem_write_enabled, mem_data_to_write
//                            memory request, all zero outside READ/WRITE
//   mem_data_out             combinational read data from the memory
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int A = ADDR_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [A-1:0] src_addr,
  input  logic [A-1:0] dst_addr,
  input  logic [A:0]   length,
  output logic         busy,
  output logic         done,
  output logic [A-1:0] mem_addr,
  output logic         mem_read_enabled,
  output logic         mem_write_enabled,
  output logic [W-1:0] mem_data_to_write,
  input  logic [W-1:0] mem_data_out
);

  copy_state_t  state_q, state_d;
  logic [A:0]   count_q, count_d;
  logic [A:0]   len_q, len_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [W-1:0] buf_q, buf_d;
  logic [A:0]   count_inc;

  // count is one bit wider than the address so length == 2**A terminates.
  assign count_inc = count_q + (A+1)'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          count_d = '0;
          state_d = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        buf_d   = mem_data_out;
        state_d = WRITE;
      end
      WRITE: begin
        count_d = count_inc;
        state_d = (count_inc == len_q) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
    end
  end

  // Outputs decode only from registered state; address sums wrap mod 2**A.
  // The write strobe is gated by reset_n so an aborting edge never writes.
  always_comb begin
    busy              = (state_q != IDLE);
    done              = (state_q == DONE);
    mem_addr          = '0;
    mem_read_enabled  = 1'b0;
    mem_write_enabled = 1'b0;
    mem_data_to_write = '0;
    case (state_q)
      READ: begin
        mem_addr         = src_q + count_q[A-1:0];
        mem_read_enabled = 1'b1;
      end
      WRITE: begin
        mem_addr          = dst_q + count_q[A-1:0];
        mem_write_enabled = reset_n;
        mem_data_to_write = buf_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator for the single-port 256x8 data memory.
- Copies a block of `length` bytes from `src_addr` to `dst_addr` using that memory's combinational-read / registered-write port.
- Sits beside the core, which owns the memory's port only while `busy` is low.
- Used for block-move support and for test/program data setup.

Parameters:
- W, 8, data width in bits; must match the memory's W.
- A, 8, address width in bits; the memory holds 2**A entries.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request; sampled only in IDLE.
- src_addr  input  A  first source address; latched when start is accepted.
- dst_addr  input  A  first destination address; latched when start is accepted.
- length  input  A+1  byte count, 0..2**A; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse when the copy completes.
- mem_addr  output  A  memory address.
- mem_read_enabled  output  1  memory read strobe.
- mem_write_enabled  output  1  memory write strobe.
- mem_data_to_write  output  W  memory write data.
- mem_data_out  input  W  memory read data; combinational from the memory.

Behaviour:
- States: IDLE, READ, WRITE, DONE. State and all working registers are clocked on posedge clk.
- Reset (reset_n=0 at a posedge):
  - state goes to IDLE; count, src, dst and buffer registers go to 0.
  - Outputs in IDLE: busy=0, done=0, mem_* all 0.
- mem_* outputs decode from registered state only; there is no combinational path from start/src_addr/dst_addr/length to any output.
- mem_write_enabled = (state==WRITE) && reset_n. No memory write can occur on an edge where reset is asserted.
- IDLE:
  - start=1 latches src, dst and length, and clears count.
  - length==0 goes to DONE; otherwise goes to READ.
  - start=0 stays in IDLE.
- READ:
  - mem_addr = src+count (mod 2**A), mem_read_enabled=1, mem_write_enabled=0.
  - At the posedge, buffer <= mem_data_out; go to WRITE.
- WRITE:
  - mem_addr = dst+count (mod 2**A), mem_write_enabled=1, mem_data_to_write=buffer, mem_read_enabled=0.
  - At the posedge: count <= count+1; if count+1 == length go to DONE, else go to READ.
- DONE: done=1, busy=1, mem_* all 0; next state is IDLE.
- Latency: 2*length + 1 cycles from start acceptance to done inclusive. length=0 gives done exactly 1 cycle after acceptance.
- start while not in IDLE is ignored; it is not queued.
- Input changes after acceptance have no effect.
- Address arithmetic wraps modulo 2**A for both source and destination; a copy crossing 0xFF continues at 0x00.
- count is A+1 bits so that length=2**A (256) terminates correctly.
- Overlap: the copy is strictly forward, byte by byte.
  - dst > src with overlapping ranges propagates already-copied bytes. This is defined behaviour, not an error.
  - dst == src rewrites identical data.
- Reset mid-operation: aborts in the same edge, no done pulse, no partial write on the reset edge. Bytes already written remain in memory.
- Outside busy, mem_* are all 0, so the core's mux can OR or select the buses safely.

Decomposition:
- Package mem_copy_pkg holds:
  - enum copy_state_t {IDLE, READ, WRITE, DONE} as logic [1:0].
  - localparams DATA_W=8 and ADDR_W=8, shared with the data memory instantiation.
- No sub-module. The block is a single FSM plus datapath; the address adders stay inline.

Test Plan:
- Preload mem[0x10..0x13]=0xA1,0xB2,0xC3,0xD4; start with src=0x10, dst=0x40, length=4 -> mem[0x40..0x43] equal the source, source unchanged, done pulses on cycle 9 after acceptance, busy high cycles 1-9.
- length=0, src=0x05, dst=0x06 -> done 1 cycle after start, mem_write_enabled never asserted, memory unchanged.
- Wrap: src=0xFE with mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33; dst=0x80, length=3 -> mem[0x80..0x82]=0x11,0x22,0x33. Also repeat with dst=0xFF, length=2 -> writes land at 0xFF then 0x00.
- Full length=256, src=0x00, dst=0x00 -> memory unchanged, done at cycle 513, count does not overflow.
- Overlap: mem[0x20..0x22]=0x01,0x02,0x03; src=0x20, dst=0x21, length=3 -> mem[0x20..0x23]=0x01,0x01,0x01,0x01. Also a second start pulsed while busy -> ignored, only one done.
- Reset abort: assert reset_n=0 on the edge where state==WRITE for byte 2 of a 4-byte copy -> that byte is not written, only byte 0 and byte 1 are written, no done pulse, next cycle busy=0 and all mem_*=0.
